// File: rtl/types_pkg.sv
// Shared rename types: decode and rename packets, register-file sizing.
package types_pkg;

  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 128;
  localparam int PREG_W    = 7;
  localparam int AREG_W    = 5;
  localparam int FL_DEPTH  = 128;
  localparam int FL_PTR_W  = $clog2(FL_DEPTH) + 1;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    areg_t       rs1;
    areg_t       rs2;
    areg_t       rd;
    logic        writes_rd;
    logic [31:0] imm;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        fu_alu;
    logic        fu_br;
    logic        fu_mem;
  } decode_data;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    areg_t       rd;
    logic        writes_rd;
    logic [31:0] imm;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        fu_alu;
    logic        fu_br;
    logic        fu_mem;
    preg_t       pd_new;
    preg_t       pd_old;
    preg_t       ps1;
    preg_t       ps2;
  } rename_data;

  function automatic logic needs_alloc(input decode_data d);
    return d.writes_rd && (d.rd != '0);
  endfunction

endpackage

// File: rtl/free_list.sv
// Circular physical-register free list with speculative head,
// committed head for recovery, and tail fed by retirement.
module free_list
  import types_pkg::*;
#(
  parameter int DEPTH = FL_DEPTH,
  parameter int INIT  = PHYS_REGS - ARCH_REGS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pop,
  input  logic                    push,
  input  logic [PREG_W-1:0]       push_preg,
  input  logic                    commit,
  input  logic                    recover,
  output logic [PREG_W-1:0]       head_preg,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] commit_head;
  logic [PW-1:0] commit_head_nxt;
  logic [PW-1:0] tail;
  preg_t         mem [DEPTH];

  // recovery must see a commit happening in the same cycle
  assign commit_head_nxt = commit_head + PW'(commit);
  assign head_preg       = mem[head[IW-1:0]];
  assign count           = tail - head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= PW'(INIT);
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i < INIT) ? preg_t'(i + ARCH_REGS) : '0;
    end else begin
      if (push) begin
        mem[tail[IW-1:0]] <= push_preg;
        tail              <= tail + PW'(1);
      end
      commit_head <= commit_head_nxt;
      if (recover)
        head <= commit_head_nxt;
      else if (pop)
        head <= head + PW'(1);
    end
  end

  a_no_underflow: assert property (
    @(posedge clk) disable iff (reset)
    pop |-> (count != '0));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    (push && !pop) |-> (count != PW'(DEPTH)));

endmodule

// File: rtl/rename_stage.sv
// Register rename stage: RAT/cRAT mapping plus free-list allocation.
// Define RENAME_STATS_EN to add rename and free-list stall counters.
module rename_stage
  import types_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  decode_data        data_in,
  output logic              ready_in,
  output logic              valid_out,
  output rename_data        data_out,
  input  logic              ready_out,
  input  logic              retire_valid,
  input  logic              retire_we,
  input  logic [AREG_W-1:0] retire_rd,
  input  logic [PREG_W-1:0] retire_pd_new,
  input  logic [PREG_W-1:0] retire_pd_old,
  input  logic              mispredict
`ifdef RENAME_STATS_EN
  ,
  output logic [31:0]       stat_renamed,
  output logic [31:0]       stat_fl_stall
`endif
);

  logic                alloc_need;
  logic                fl_empty;
  logic                accept;
  logic                pop;
  logic                do_retire;
  logic                fl_push;
  logic [PREG_W-1:0]   fl_head_preg;
  logic [FL_PTR_W-1:0] fl_count;
  preg_t               rat      [ARCH_REGS];
  preg_t               crat     [ARCH_REGS];
  preg_t               crat_nxt [ARCH_REGS];
  rename_data          pkt;

  assign alloc_need = needs_alloc(data_in);
  assign fl_empty   = (fl_count == '0);
  assign ready_in   = !mispredict
                   && (!valid_out || ready_out)
                   && (!alloc_need || !fl_empty);
  assign accept     = valid_in && ready_in;
  assign pop        = accept && alloc_need;
  assign do_retire  = retire_valid && retire_we;
  assign fl_push    = do_retire && (retire_pd_old != '0);

  free_list #(
    .DEPTH (FL_DEPTH)
  ) u_fl (
    .clk       (clk),
    .reset     (reset),
    .pop       (pop),
    .push      (fl_push),
    .push_preg (retire_pd_old),
    .commit    (do_retire),
    .recover   (mispredict),
    .head_preg (fl_head_preg),
    .count     (fl_count)
  );

  // committed map including this cycle's retire, used for recovery
  always_comb begin
    crat_nxt = crat;
    if (do_retire && (retire_rd != '0))
      crat_nxt[retire_rd] = retire_pd_new;
  end

  always_comb begin
    pkt           = '0;
    pkt.pc        = data_in.pc;
    pkt.opcode    = data_in.opcode;
    pkt.rd        = data_in.rd;
    pkt.writes_rd = data_in.writes_rd;
    pkt.imm       = data_in.imm;
    pkt.func3     = data_in.func3;
    pkt.func7     = data_in.func7;
    pkt.fu_alu    = data_in.fu_alu;
    pkt.fu_br     = data_in.fu_br;
    pkt.fu_mem    = data_in.fu_mem;
    pkt.ps1       = rat[data_in.rs1];
    pkt.ps2       = rat[data_in.rs2];
    if (alloc_need) begin
      pkt.pd_old = rat[data_in.rd];
      pkt.pd_new = fl_head_preg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++)
        rat[i] <= preg_t'(i);
    end else if (mispredict) begin
      rat <= crat_nxt;
    end else if (pop) begin
      rat[data_in.rd] <= fl_head_preg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++)
        crat[i] <= preg_t'(i);
    end else begin
      crat <= crat_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (mispredict) begin
      valid_out <= 1'b0;
    end else if (accept) begin
      valid_out <= 1'b1;
      data_out  <= pkt;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

`ifdef RENAME_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_renamed  <= '0;
      stat_fl_stall <= '0;
    end else begin
      if (accept && (stat_renamed != '1))
        stat_renamed <= stat_renamed + 32'd1;
      if (valid_in && alloc_need && fl_empty && (stat_fl_stall != '1))
        stat_fl_stall <= stat_fl_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: scoreboarded packets plus
// directed checks of stalls, hold, recovery and reset.
module tb_rename_stage;
  import types_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  decode_data data_in = '0;
  logic       ready_in;
  logic       valid_out;
  rename_data data_out;
  logic       ready_out = 1'b1;
  logic       retire_valid = 1'b0;
  logic       retire_we = 1'b0;
  areg_t      retire_rd = '0;
  preg_t      retire_pd_new = '0;
  preg_t      retire_pd_old = '0;
  logic       mispredict = 1'b0;
`ifdef RENAME_STATS_EN
  logic [31:0] stat_renamed;
  logic [31:0] stat_fl_stall;
`endif

  int checks = 0;
  int passed = 0;

  rename_data sb [$];
  rename_data mon_exp;

  preg_t m_rat  [32];
  preg_t m_crat [32];
  preg_t m_fl   [128];
  int    m_head, m_chead, m_tail;

  always #5 clk = ~clk;

  rename_stage dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .ready_in      (ready_in),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .ready_out     (ready_out),
    .retire_valid  (retire_valid),
    .retire_we     (retire_we),
    .retire_rd     (retire_rd),
    .retire_pd_new (retire_pd_new),
    .retire_pd_old (retire_pd_old),
    .mispredict    (mispredict)
`ifdef RENAME_STATS_EN
    ,
    .stat_renamed  (stat_renamed),
    .stat_fl_stall (stat_fl_stall)
`endif
  );

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_rat[i]  = preg_t'(i);
      m_crat[i] = preg_t'(i);
    end
    for (int i = 0; i < 128; i++)
      m_fl[i] = (i < 96) ? preg_t'(i + 32) : '0;
    m_head  = 0;
    m_chead = 0;
    m_tail  = 96;
  endfunction

  function automatic rename_data m_rename(input decode_data d);
    rename_data e;
    e           = '0;
    e.pc        = d.pc;
    e.opcode    = d.opcode;
    e.rd        = d.rd;
    e.writes_rd = d.writes_rd;
    e.imm       = d.imm;
    e.func3     = d.func3;
    e.func7     = d.func7;
    e.fu_alu    = d.fu_alu;
    e.fu_br     = d.fu_br;
    e.fu_mem    = d.fu_mem;
    e.ps1       = m_rat[d.rs1];
    e.ps2       = m_rat[d.rs2];
    if (d.writes_rd && d.rd != 0) begin
      e.pd_old     = m_rat[d.rd];
      e.pd_new     = m_fl[m_head % 128];
      m_head++;
      m_rat[d.rd]  = e.pd_new;
    end
    return e;
  endfunction

  function automatic void m_retire(input int rd, input int pn, input int po);
    if (po != 0) begin
      m_fl[m_tail % 128] = preg_t'(po);
      m_tail++;
    end
    if (rd != 0) m_crat[rd] = preg_t'(pn);
    m_chead++;
  endfunction

  function automatic void m_flush();
    m_rat  = m_crat;
    m_head = m_chead;
  endfunction

  function automatic decode_data mk(input int rs1, input int rs2,
                                    input int rd, input bit w);
    decode_data d;
    d.pc        = $urandom;
    d.opcode    = w ? 7'h33 : 7'h23;
    d.rs1       = areg_t'(rs1);
    d.rs2       = areg_t'(rs2);
    d.rd        = areg_t'(rd);
    d.writes_rd = w;
    d.imm       = $urandom;
    d.func3     = 3'($urandom_range(7));
    d.func7     = 7'($urandom_range(127));
    d.fu_alu    = w;
    d.fu_br     = 1'b0;
    d.fu_mem    = !w;
    return d;
  endfunction

  // packets leave at the edge following a negedge with valid && ready
  always @(negedge clk) begin
    if (reset === 1'b0 && valid_out && ready_out) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_underflow: got pd_new=%0d with no packet expected",
                 data_out.pd_new);
      end else begin
        mon_exp = sb.pop_front();
        if (data_out !== mon_exp)
          $display("FAIL sb_packet: got pd_new=%0d pd_old=%0d ps1=%0d ps2=%0d pc=%h, want pd_new=%0d pd_old=%0d ps1=%0d ps2=%0d pc=%h",
                   data_out.pd_new, data_out.pd_old, data_out.ps1, data_out.ps2, data_out.pc,
                   mon_exp.pd_new, mon_exp.pd_old, mon_exp.ps1, mon_exp.ps2, mon_exp.pc);
        else
          passed++;
      end
    end
  end

  // called between posedge+1 and the negedge; returns at posedge+1
  task automatic send(input decode_data d);
    int n = 0;
    data_in  = d;
    valid_in = 1'b1;
    @(negedge clk);
    while (!ready_in && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_in) begin
      checks++;
      $display("FAIL send_timeout: ready_in=%0b after %0d cycles, want 1", ready_in, n);
      @(posedge clk);
      #1 valid_in = 1'b0;
      return;
    end
    sb.push_back(m_rename(d));
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic do_reset();
    valid_in     = 1'b0;
    data_in      = '0;
    retire_valid = 1'b0;
    retire_we    = 1'b0;
    mispredict   = 1'b0;
    ready_out    = 1'b1;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid_out);
    else passed++;
    checks++;
    if (data_out !== '0) $display("FAIL reset_data: got %h want 0", data_out);
    else passed++;
    checks++;
    if (ready_in !== 1'b1) $display("FAIL reset_ready: got %0b want 1", ready_in);
    else passed++;
    checks++;
    if (dut.fl_count !== 8'd96) $display("FAIL reset_fl_count: got %0d want 96", dut.fl_count);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    send(mk(1, 2, 5, 1));
    #2;
    checks++;
    if ({data_out.ps1, data_out.ps2, data_out.pd_old, data_out.pd_new}
        !== {7'd1, 7'd2, 7'd5, 7'd32})
      $display("FAIL basic_first: got ps1=%0d ps2=%0d pd_old=%0d pd_new=%0d want 1 2 5 32",
               data_out.ps1, data_out.ps2, data_out.pd_old, data_out.pd_new);
    else passed++;
    send(mk(5, 2, 5, 1));
    #2;
    checks++;
    if ({data_out.ps1, data_out.pd_old, data_out.pd_new} !== {7'd32, 7'd32, 7'd33})
      $display("FAIL basic_second: got ps1=%0d pd_old=%0d pd_new=%0d want 32 32 33",
               data_out.ps1, data_out.pd_old, data_out.pd_new);
    else passed++;
  endtask

  task automatic test_no_alloc();
    logic [7:0] cnt;
    @(posedge clk);
    #1 cnt = dut.fl_count;
    send(mk(3, 4, 5, 0));
    #2;
    checks++;
    if ({data_out.pd_new, data_out.pd_old} !== 14'd0 || dut.fl_count !== cnt)
      $display("FAIL store_no_alloc: got pd_new=%0d pd_old=%0d count=%0d want 0 0 %0d",
               data_out.pd_new, data_out.pd_old, dut.fl_count, cnt);
    else passed++;
    send(mk(0, 5, 0, 1));
    #2;
    checks++;
    if ({data_out.pd_new, data_out.pd_old, data_out.ps1} !== 21'd0
        || data_out.ps2 !== 7'd33 || dut.fl_count !== cnt)
      $display("FAIL x0_no_alloc: got pd_new=%0d pd_old=%0d ps1=%0d ps2=%0d count=%0d want 0 0 0 33 %0d",
               data_out.pd_new, data_out.pd_old, data_out.ps1, data_out.ps2, dut.fl_count, cnt);
    else passed++;
  endtask

  task automatic test_hold();
    rename_data snap;
    logic [7:0] cnt;
    decode_data b;
    @(posedge clk);
    #1 ready_out = 1'b0;
    send(mk(7, 8, 9, 1));
    #2;
    snap = data_out;
    cnt  = dut.fl_count;
    b    = mk(9, 1, 10, 1);
    data_in  = b;
    valid_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ready_in !== 1'b0 || valid_out !== 1'b1 || data_out !== snap
          || dut.fl_count !== cnt)
        $display("FAIL hold_stable: got ready_in=%0b valid=%0b pd_new=%0d count=%0d want 0 1 %0d %0d",
                 ready_in, valid_out, data_out.pd_new, dut.fl_count, snap.pd_new, cnt);
      else passed++;
    end
    @(posedge clk);
    #1 ready_out = 1'b1;
    #1;
    checks++;
    if (ready_in !== 1'b1) $display("FAIL hold_release: ready_in got %0b want 1", ready_in);
    else passed++;
    sb.push_back(m_rename(b));
    @(posedge clk);
    #1 valid_in = 1'b0;
    #2;
    checks++;
    if (valid_out !== 1'b1 || data_out.rd !== 5'd10 || data_out.ps1 !== 7'd34)
      $display("FAIL hold_next: got valid=%0b rd=%0d ps1=%0d want 1 10 34",
               valid_out, data_out.rd, data_out.ps1);
    else passed++;
  endtask

  task automatic test_stall();
    decode_data d;
    do_reset();
    for (int i = 0; i < 96; i++)
      send(mk(i % 32, (i * 7) % 32, (i % 31) + 1, 1));
    #2;
    checks++;
    if (dut.fl_count !== 8'd0) $display("FAIL stall_empty: count got %0d want 0", dut.fl_count);
    else passed++;
    d             = mk(1, 2, 12, 1);
    data_in       = d;
    valid_in      = 1'b1;
    retire_valid  = 1'b1;
    retire_we     = 1'b1;
    retire_rd     = 5'd7;
    retire_pd_new = 7'd38;
    retire_pd_old = 7'd7;
    @(negedge clk);
    checks++;
    if (ready_in !== 1'b0) $display("FAIL stall_no_bypass: ready_in got %0b want 0", ready_in);
    else passed++;
    @(posedge clk);
    #1;
    retire_valid = 1'b0;
    retire_we    = 1'b0;
    m_retire(7, 38, 7);
    #1;
    checks++;
    if (ready_in !== 1'b1) $display("FAIL stall_freed: ready_in got %0b want 1", ready_in);
    else passed++;
    sb.push_back(m_rename(d));
    @(posedge clk);
    #1 valid_in = 1'b0;
    #2;
    checks++;
    if (data_out.pd_new !== 7'd7) $display("FAIL stall_reuse: pd_new got %0d want 7", data_out.pd_new);
    else passed++;
`ifdef RENAME_STATS_EN
    checks++;
    if (stat_renamed !== 32'd97 || stat_fl_stall !== 32'd1)
      $display("FAIL stats_count: got renamed=%0d stall=%0d want 97 1", stat_renamed, stat_fl_stall);
    else passed++;
`endif
  endtask

  task automatic test_mispredict();
    do_reset();
    send(mk(0, 0, 3, 1));
    send(mk(0, 0, 3, 1));
    send(mk(3, 0, 4, 1));
    ready_out     = 1'b0;
    retire_valid  = 1'b1;
    retire_we     = 1'b1;
    retire_rd     = 5'd3;
    retire_pd_new = 7'd32;
    retire_pd_old = 7'd3;
    @(posedge clk);
    #1;
    retire_valid = 1'b0;
    retire_we    = 1'b0;
    m_retire(3, 32, 3);
    mispredict = 1'b1;
    #1;
    checks++;
    if (ready_in !== 1'b0 || valid_out !== 1'b1)
      $display("FAIL flush_pending: got ready_in=%0b valid=%0b want 0 1", ready_in, valid_out);
    else passed++;
    @(posedge clk);
    #1 mispredict = 1'b0;
    m_flush();
    void'(sb.pop_back());
    #2;
    checks++;
    if (valid_out !== 1'b0 || dut.u_fl.head !== 8'd1 || dut.u_fl.commit_head !== 8'd1)
      $display("FAIL flush_state: got valid=%0b head=%0d commit_head=%0d want 0 1 1",
               valid_out, dut.u_fl.head, dut.u_fl.commit_head);
    else passed++;
    ready_out = 1'b1;
    send(mk(3, 4, 6, 1));
    #2;
    checks++;
    if (data_out.ps1 !== 7'd32 || data_out.pd_new !== 7'd33)
      $display("FAIL flush_next: got ps1=%0d pd_new=%0d want 32 33", data_out.ps1, data_out.pd_new);
    else passed++;
  endtask

  task automatic test_flush_same_cycle();
    do_reset();
    send(mk(0, 0, 3, 1));
    send(mk(0, 0, 3, 1));
    retire_valid  = 1'b1;
    retire_we     = 1'b1;
    retire_rd     = 5'd3;
    retire_pd_new = 7'd32;
    retire_pd_old = 7'd3;
    mispredict    = 1'b1;
    @(posedge clk);
    #1;
    retire_valid = 1'b0;
    retire_we    = 1'b0;
    mispredict   = 1'b0;
    m_retire(3, 32, 3);
    m_flush();
    send(mk(3, 3, 6, 1));
    #2;
    checks++;
    if (data_out.ps1 !== 7'd32 || data_out.ps2 !== 7'd32 || data_out.pd_new !== 7'd33)
      $display("FAIL flush_fwd: got ps1=%0d ps2=%0d pd_new=%0d want 32 32 33",
               data_out.ps1, data_out.ps2, data_out.pd_new);
    else passed++;
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #1 ready_out = 1'b0;
    send(mk(1, 2, 5, 1));
    #1 reset = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== '0 || dut.fl_count !== 8'd96)
      $display("FAIL async_reset: got valid=%0b data=%h count=%0d want 0 0 96",
               valid_out, data_out, dut.fl_count);
    else passed++;
`ifdef RENAME_STATS_EN
    checks++;
    if (stat_renamed !== 32'd0 || stat_fl_stall !== 32'd0)
      $display("FAIL stats_reset: got renamed=%0d stall=%0d want 0 0", stat_renamed, stat_fl_stall);
    else passed++;
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
    sb.delete();
    ready_out = 1'b1;
    send(mk(5, 3, 0, 0));
    #2;
    checks++;
    if (data_out.ps1 !== 7'd5 || data_out.ps2 !== 7'd3)
      $display("FAIL reset_identity: got ps1=%0d ps2=%0d want 5 3", data_out.ps1, data_out.ps2);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_alloc();
    test_hold();
    test_stall();
    test_mispredict();
    test_flush_same_cycle();
    test_async_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d packets want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
